mem_arbiter2: RTL and testbench

Two-master arbiter that shares one picorv32-style native memory port (valid/ready handshake) between requesters, e.g. CPU and a DMA/signature-dump engine, in front of the torture-test memory model. Round-robin grant, transaction held until slave ready, plus a watchdog that force-completes hung transactions and flags a sticky error.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_wdog.sv | 32 +++
 rtl/mem_arbiter2.sv | 119 +++++++++++
 tb/tb_mem_arbiter2.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master native memory port arbiter.
// Pure declarations; no logic.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int WDOG_W = $clog2(65536);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog cycle counter; expire flags the TIMEOUT-th counted cycle.
// Latency: expire is combinational from the count register.
// Backpressure: none; clear has priority over enable.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing one valid/ready memory port between two masters.
// Latency: grant one cycle after request; owner ready is combinational from s_ready.
// Backpressure: owner held until s_ready or watchdog expiry; one IDLE cycle between grants.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        gnt,
    output logic              timeout_err
);

    state_t state, state_nxt;
    logic   owner, last_owner;
    logic   busy, own_valid, expire, forced, done, pick;
    logic   wdog_clr, wdog_en;
    req_t   m0_req, m1_req, own_req;

    assign m0_req    = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
    assign m1_req    = {m1_instr, m1_addr, m1_wdata, m1_wstrb};
    assign own_req   = owner ? m1_req : m0_req;
    assign own_valid = owner ? m1_valid : m0_valid;

    assign busy   = (state == BUSY);
    // a real slave response in the expiry cycle wins over the watchdog
    assign forced = busy & ~s_ready & expire;
    assign done   = busy & (s_ready | forced);
    assign pick   = (m0_valid & m1_valid) ? ~last_owner : m1_valid;

    assign wdog_clr = ~busy | s_ready | expire;
    assign wdog_en  = busy & ~s_ready;

    mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_valid | m1_valid) state_nxt = BUSY;
            BUSY:    if (done)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        gnt      = 2'b00;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (busy) begin
            s_valid = own_valid & ~forced;
            if (owner) begin
                gnt      = 2'b10;
                m1_ready = s_ready | forced;
                m1_rdata = forced ? '0 : s_rdata;
            end else begin
                gnt      = 2'b01;
                m0_ready = s_ready | forced;
                m0_rdata = forced ? '0 : s_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            if (!busy && (m0_valid || m1_valid)) owner <= pick;
            if (done)   last_owner  <= owner;
            if (forced) timeout_err <= 1'b1;
        end
    end

    assign s_instr = own_req.instr;
    assign s_addr  = own_req.addr;
    assign s_wdata = own_req.wdata;
    assign s_wstrb = own_req.wstrb;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: random masters and slave against a transaction-level model.
module tb_mem_arbiter2;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mv[2];
    logic        minstr[2];
    logic [31:0] maddr[2];
    logic [31:0] mwdata[2];
    logic [3:0]  mwstrb[2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  gnt;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(mv[0]), .m0_instr(minstr[0]), .m0_addr(maddr[0]),
        .m0_wdata(mwdata[0]), .m0_wstrb(mwstrb[0]), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(mv[1]), .m1_instr(minstr[1]), .m1_addr(maddr[1]),
        .m1_wdata(mwdata[1]), .m1_wstrb(mwstrb[1]), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .gnt(gnt), .timeout_err(timeout_err)
    );

    int tests = 0;
    int fails = 0;

    // model state: transaction level, busy_cycles counts BUSY cycles since grant (1-based)
    logic md_busy = 1'b0, md_own = 1'b0, md_last = 1'b1, md_err = 1'b0;
    int   md_cyc = 0;
    int   glog[$];
    logic [31:0] smem[256];
    logic [31:0] emem[256];

    // stimulus state
    int   pend[2];
    logic done[2];
    int   rdy_cnt[2];
    int   rdy_bcnt[2];
    logic [31:0] last_rdata[2];
    int   mode = 0;
    int   at_n = 0;
    int   bsy_cnt = 0;
    int   fix_addr = -1;
    int   fix_wstrb = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic model_cycle();
        logic        forced, e_sv;
        logic        e_rdy[2];
        logic [31:0] e_rd[2];
        logic [1:0]  e_gnt;
        forced = md_busy && !s_ready && (md_cyc == TO);
        e_sv = 1'b0; e_gnt = 2'b00;
        e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
        if (md_busy) begin
            e_gnt = md_own ? 2'b10 : 2'b01;
            e_sv  = mv[md_own] && !forced;
            e_rdy[md_own] = s_ready || forced;
            e_rd[md_own]  = forced ? 32'h0 : s_rdata;
        end
        check("gnt", {30'h0, gnt}, {30'h0, e_gnt});
        check("s_valid", {31'h0, s_valid}, {31'h0, e_sv});
        check("m0_ready", {31'h0, m0_ready}, {31'h0, e_rdy[0]});
        check("m1_ready", {31'h0, m1_ready}, {31'h0, e_rdy[1]});
        check("m0_rdata", m0_rdata, e_rd[0]);
        check("m1_rdata", m1_rdata, e_rd[1]);
        check("timeout_err", {31'h0, timeout_err}, {31'h0, md_err});
        if (e_sv) begin
            check("s_addr", s_addr, maddr[md_own]);
            check("s_wdata", s_wdata, mwdata[md_own]);
            check("s_wstrb", {28'h0, s_wstrb}, {28'h0, mwstrb[md_own]});
            check("s_instr", {31'h0, s_instr}, {31'h0, minstr[md_own]});
        end
        done[0] = mv[0] && m0_ready;
        done[1] = mv[1] && m1_ready;
        if (m0_ready) begin rdy_cnt[0]++; rdy_bcnt[0] = bsy_cnt; last_rdata[0] = m0_rdata; end
        if (m1_ready) begin rdy_cnt[1]++; rdy_bcnt[1] = bsy_cnt; last_rdata[1] = m1_rdata; end
        if (md_busy && s_ready && mv[md_own] && mwstrb[md_own] != 4'h0)
            emem[maddr[md_own][9:2]] = merge(emem[maddr[md_own][9:2]], mwdata[md_own], mwstrb[md_own]);
        if (!resetn) begin
            md_busy = 1'b0; md_own = 1'b0; md_last = 1'b1; md_err = 1'b0; md_cyc = 0;
        end else if (md_busy) begin
            if (s_ready || forced) begin
                md_busy = 1'b0;
                md_last = md_own;
                if (forced) md_err = 1'b1;
            end else begin
                md_cyc++;
            end
        end else if (mv[0] || mv[1]) begin
            md_own  = (mv[0] && mv[1]) ? !md_last : mv[1];
            md_busy = 1'b1;
            md_cyc  = 1;
            glog.push_back(int'(md_own));
        end
    endtask

    task automatic new_fields(input int j);
        maddr[j]  = (fix_addr >= 0) ? 32'(fix_addr) : 32'h100 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if (fix_wstrb >= 0) mwstrb[j] = 4'(fix_wstrb);
        else mwstrb[j] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        mwdata[j] = $urandom;
        minstr[j] = (mwstrb[j] == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic drive_masters();
        for (int j = 0; j < 2; j++) begin
            if (done[j]) begin
                pend[j]--;
                if (pend[j] > 0) new_fields(j);
                else mv[j] = 1'b0;
            end else if (!mv[j] && pend[j] > 0) begin
                mv[j] = 1'b1;
                new_fields(j);
            end
            done[j] = 1'b0;
        end
    endtask

    task automatic drive_slave();
        logic sr;
        bsy_cnt = (gnt != 2'b00) ? bsy_cnt + 1 : 0;
        case (mode)
            0:       sr = 1'($urandom_range(0, 1));
            1:       sr = (gnt != 2'b00) && (bsy_cnt == 2);
            3:       sr = (gnt != 2'b00) && (bsy_cnt == at_n);
            default: sr = 1'b0;
        endcase
        if (!resetn) sr = 1'b0;
        s_ready = sr;
        #1;
        s_rdata = $urandom;
        if (sr && s_valid) begin
            if (s_wstrb == 4'h0) s_rdata = smem[s_addr[9:2]];
            else smem[s_addr[9:2]] = merge(smem[s_addr[9:2]], s_wdata, s_wstrb);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive_masters();
        #1;
        drive_slave();
    endtask

    task automatic run(input string name, input int budget);
        int n = 0;
        while ((pend[0] > 0 || pend[1] > 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, {31'h0, (n >= budget)}, 32'h0);
        step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
    endtask

    task automatic clear_stats();
        for (int j = 0; j < 2; j++) begin
            rdy_cnt[j] = 0; rdy_bcnt[j] = 0; last_rdata[j] = 32'hx;
        end
        glog.delete();
    endtask

    initial begin
        int exp_log[5];
        int n;
        int mism;
        for (int j = 0; j < 2; j++) begin
            mv[j] = 1'b0; minstr[j] = 1'b0; maddr[j] = '0; mwdata[j] = '0; mwstrb[j] = '0;
            pend[j] = 0; done[j] = 1'b0;
        end
        for (int i = 0; i < 256; i++) begin
            smem[i] = $urandom;
            emem[i] = smem[i];
        end
        clear_stats();
        @(posedge clk);
        #2;
        step(); step(); step();
        check("reset_gnt", {30'h0, gnt}, 32'h0);
        check("reset_err", {31'h0, timeout_err}, 32'h0);
        resetn = 1'b1;
        step();

        // single read from m0, slave answers one cycle after s_valid
        clear_stats();
        mode = 1; fix_addr = 32'h100; fix_wstrb = 0;
        smem[64] = 32'hDEADBEEF; emem[64] = 32'hDEADBEEF;
        pend[0] = 1;
        run("single", 50);
        check("single_rdata", last_rdata[0], 32'hDEADBEEF);
        check("single_m0_cnt", rdy_cnt[0], 1);
        check("single_m1_cnt", rdy_cnt[1], 0);
        check("single_lat", rdy_bcnt[0], 2);

        // contention from reset with a random slave
        fix_addr = -1; fix_wstrb = -1; mode = 0;
        resetn = 1'b0;
        pend[0] = 6; pend[1] = 6;
        step(); step();
        clear_stats();
        resetn = 1'b1;
        run("contend", 3000);
        check("contend_len", glog.size(), 12);
        for (int i = 0; i < 12 && i < glog.size(); i++)
            check("contend_order", glog[i], i % 2);
        mism = 0;
        for (int i = 0; i < 256; i++) if (smem[i] !== emem[i]) mism++;
        check("contend_mem", mism, 0);

        // arrival order after m1 served, then m0 back to back
        mode = 1;
        clear_stats();
        pend[1] = 1; run("arr_a", 50);
        pend[0] = 1; pend[1] = 1; run("arr_b", 50);
        pend[0] = 2; run("arr_c", 50);
        exp_log = '{1, 0, 1, 0, 0};
        check("arr_len", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            check("arr_order", glog[i], exp_log[i]);

        // hung slave on an m1 write
        clear_stats();
        mode = 2; fix_wstrb = 15;
        pend[1] = 1; run("hang", 100);
        check("hang_lat", rdy_bcnt[1], TO);
        check("hang_rdata", last_rdata[1], 32'h0);
        check("hang_err", {31'h0, timeout_err}, 32'h1);
        mode = 1; fix_wstrb = -1;
        pend[0] = 1; run("after_hang", 50);
        check("after_hang_cnt", rdy_cnt[0], 1);
        check("after_hang_lat", rdy_bcnt[0], 2);
        check("after_hang_err", {31'h0, timeout_err}, 32'h1);

        // slave answers exactly in the expiry cycle
        do_reset();
        check("edge_err_clr", {31'h0, timeout_err}, 32'h0);
        clear_stats();
        mode = 3; at_n = TO; fix_addr = 32'h104; fix_wstrb = 0;
        smem[65] = 32'h12345678; emem[65] = 32'h12345678;
        pend[0] = 1; run("edge", 100);
        check("edge_lat", rdy_bcnt[0], TO);
        check("edge_rdata", last_rdata[0], 32'h12345678);
        check("edge_err", {31'h0, timeout_err}, 32'h0);

        // reset in the BUSY cycle before a pending slave response
        fix_addr = -1; fix_wstrb = -1; mode = 1;
        clear_stats();
        pend[0] = 1;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin step(); n++; end
        check("rst_busy_seen", {30'h0, gnt}, 32'h1);
        resetn = 1'b0;
        pend[1] = 1;
        step();
        check("rst_mid_gnt", {30'h0, gnt}, 32'h0);
        check("rst_mid_svalid", {31'h0, s_valid}, 32'h0);
        check("rst_mid_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
        clear_stats();
        resetn = 1'b1;
        run("rst_after", 50);
        check("rst_after_len", glog.size(), 2);
        if (glog.size() > 0) check("rst_after_first", glog[0], 0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (smem[i] !== emem[i]) mism++;
        check("final_mem", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
